// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter (fetch m0, data m1) onto one shared slave bus.
// Optional ACK watchdog enabled by defining MOXIE_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G0   = 2'd1;
  localparam logic [1:0] G1   = 2'd2;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_rr_arbiter: TIMEOUT must be 1..65535");
  end

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;   // 1 = m1 served last, so m0 wins the next tie
  logic       g0, g1, tmo;

  assign g0    = (state_q == G0);
  assign g1    = (state_q == G1);
  assign gnt_o = {g1, g0};

`ifdef MOXIE_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts strobe cycles still waiting for a response; the cycle it hits TIMEOUT
  // kills the strobe, which in turn clears the counter.
  assign tmo = (state_q != IDLE) && (cnt_q == 16'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!s_stb_o || s_ack_i || s_err_i) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? G0 : G1;
        else if (m0_cyc_i)        state_d = G0;
        else if (m1_cyc_i)        state_d = G1;
      end
      G0: begin
        if (!m0_cyc_i || tmo) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? G1 : IDLE;
        end
      end
      G1: begin
        if (!m1_cyc_i || tmo) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? G0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Slave side follows the owner combinationally; everything is zero while idle.
  assign s_cyc_o = ((g0 & m0_cyc_i) | (g1 & m1_cyc_i)) & ~tmo;
  assign s_stb_o = ((g0 & m0_stb_i) | (g1 & m1_stb_i)) & ~tmo;
  assign s_we_o  = (g0 & m0_we_i) | (g1 & m1_we_i);
  assign s_adr_o = g0 ? m0_adr_i : (g1 ? m1_adr_i : '0);
  assign s_dat_o = g0 ? m0_dat_i : (g1 ? m1_dat_i : '0);
  assign s_sel_o = g0 ? m0_sel_i : (g1 ? m1_sel_i : '0);

  assign m0_ack_o = s_ack_i & g0;
  assign m1_ack_o = s_ack_i & g1;
  assign m0_err_o = (s_err_i | tmo) & g0;
  assign m1_err_o = (s_err_i | tmo) & g1;
  assign m0_dat_o = g0 ? s_dat_i : '0;
  assign m1_dat_o = g1 ? s_dat_i : '0;

endmodule
